// File: rtl/race_controller_pkg.sv
// Shared definitions for the race sequencer: game state codes and time helpers.
// The physics engines import this package so the state encoding has one source.
package race_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_SYNCING   = 3'd2,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } race_state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  // Saturating centisecond increment; never wraps past the limit.
  function automatic logic [15:0] cs_inc(input logic [15:0] cs, input logic [15:0] lim);
    if (cs >= lim) begin
      return cs;
    end else begin
      return cs + 16'd1;
    end
  endfunction

  // A latched finish time of 0 means "not finished", so a finish at t=0 records 1.
  function automatic logic [15:0] finish_stamp(input logic [15:0] cs);
    if (cs == 16'd0) begin
      return 16'd1;
    end else begin
      return cs;
    end
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter producing a 1-cycle tick on its last count.
// Holds its count while disabled; clr forces the count back to zero.
module tick_divider #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = en && (count_q >= LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q >= LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: start countdown, centisecond race clock with pause, and
// winner / per-car finish-time latching. All outputs come straight from flops.
module race_controller
  import race_controller_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned COUNTDOWN_SEC = 3,
  parameter logic [15:0] TIME_MAX      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic        abort_pulse,
  input  logic        p1_finish,
  input  logic        p2_finish,
  output logic [2:0]  state,
  output logic [3:0]  countdown,
  output logic        go_pulse,
  output logic [15:0] race_cs,
  output logic [15:0] p1_time_cs,
  output logic [15:0] p2_time_cs,
  output logic [1:0]  winner
);

  localparam int unsigned CS_DIV  = CLK_FREQ / 100;
  localparam logic [3:0]  CD_LOAD = 4'(COUNTDOWN_SEC);

  race_state_e state_q, state_d;
  logic [3:0]  countdown_q, countdown_d;
  logic        go_q, go_d;
  logic [15:0] race_cs_q, race_cs_d;
  logic [15:0] p1_time_q, p1_time_d;
  logic [15:0] p2_time_q, p2_time_d;
  logic [1:0]  winner_q, winner_d;

  logic sec_tick_s, cs_tick_s;
  logic sec_clr_s, sec_en_s, cs_clr_s, cs_en_s;

  // The cs divider keeps its phase across PAUSE and only clears outside a race.
  assign sec_en_s  = (state_q == ST_COUNTDOWN);
  assign sec_clr_s = (state_q != ST_COUNTDOWN) || abort_pulse;
  assign cs_en_s   = (state_q == ST_RACING);
  assign cs_clr_s  = !((state_q == ST_RACING) || (state_q == ST_PAUSE)) || abort_pulse;

  tick_divider #(.DIV(CLK_FREQ)) u_sec_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sec_clr_s),
    .en    (sec_en_s),
    .tick  (sec_tick_s)
  );

  tick_divider #(.DIV(CS_DIV)) u_cs_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cs_clr_s),
    .en    (cs_en_s),
    .tick  (cs_tick_s)
  );

  // Next-state and timing-register logic; abort and IDLE entry clear everything.
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    go_d        = 1'b0;
    race_cs_d   = race_cs_q;
    p1_time_d   = p1_time_q;
    p2_time_d   = p2_time_q;
    winner_d    = winner_q;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d = ST_SETTING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTING: begin
        if (start_pulse) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = CD_LOAD;
        end else begin
          state_d = ST_SETTING;
        end
      end
      ST_COUNTDOWN: begin
        if (sec_tick_s) begin
          if (countdown_q <= 4'd1) begin
            state_d     = ST_RACING;
            countdown_d = 4'd0;
            go_d        = 1'b1;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end else begin
          countdown_d = countdown_q;
        end
      end
      ST_RACING: begin
        if (cs_tick_s) begin
          race_cs_d = cs_inc(race_cs_q, TIME_MAX);
        end else begin
          race_cs_d = race_cs_q;
        end
        // A finish outranks a simultaneous pause request.
        if (p1_finish || p2_finish) begin
          state_d  = ST_FINISH;
          winner_d = {p2_finish, p1_finish};
          if (p1_finish) begin
            p1_time_d = finish_stamp(race_cs_q);
          end else begin
            p1_time_d = p1_time_q;
          end
          if (p2_finish) begin
            p2_time_d = finish_stamp(race_cs_q);
          end else begin
            p2_time_d = p2_time_q;
          end
        end else if (pause_pulse) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RACING;
        end
      end
      ST_PAUSE: begin
        if (pause_pulse) begin
          state_d = ST_RACING;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_FINISH: begin
        if (p1_finish && (p1_time_q == 16'd0)) begin
          p1_time_d = finish_stamp(race_cs_q);
        end else begin
          p1_time_d = p1_time_q;
        end
        if (p2_finish && (p2_time_q == 16'd0)) begin
          p2_time_d = finish_stamp(race_cs_q);
        end else begin
          p2_time_d = p2_time_q;
        end
        if (start_pulse) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_pulse || (state_d == ST_IDLE)) begin
      state_d     = ST_IDLE;
      countdown_d = 4'd0;
      go_d        = 1'b0;
      race_cs_d   = 16'd0;
      p1_time_d   = 16'd0;
      p2_time_d   = 16'd0;
      winner_d    = WIN_NONE;
    end else begin
      state_d = state_d;
    end
  end

  // State and timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      countdown_q <= 4'd0;
      go_q        <= 1'b0;
      race_cs_q   <= 16'd0;
      p1_time_q   <= 16'd0;
      p2_time_q   <= 16'd0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      go_q        <= go_d;
      race_cs_q   <= race_cs_d;
      p1_time_q   <= p1_time_d;
      p2_time_q   <= p2_time_d;
      winner_q    <= winner_d;
    end
  end

  assign state      = state_q;
  assign countdown  = countdown_q;
  assign go_pulse   = go_q;
  assign race_cs    = race_cs_q;
  assign p1_time_cs = p1_time_q;
  assign p2_time_cs = p2_time_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller (CLK_FREQ=1000: 1 s = 1000 cycles, 1 cs = 10 cycles).
// A second instance with TIME_MAX=20 shares all stimulus for the saturation case.
module tb_race_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_pulse = 1'b0, pause_pulse = 1'b0, abort_pulse = 1'b0;
  logic p1_finish = 1'b0, p2_finish = 1'b0;

  logic [2:0]  state, s_state;
  logic [3:0]  countdown, s_countdown;
  logic        go_pulse, s_go_pulse;
  logic [15:0] race_cs, p1_time_cs, p2_time_cs, s_race_cs, s_p1_time_cs, s_p2_time_cs;
  logic [1:0]  winner, s_winner;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  race_controller #(.CLK_FREQ(1000), .COUNTDOWN_SEC(3), .TIME_MAX(16'hFFFF)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .abort_pulse(abort_pulse), .p1_finish(p1_finish), .p2_finish(p2_finish),
    .state(state), .countdown(countdown), .go_pulse(go_pulse), .race_cs(race_cs),
    .p1_time_cs(p1_time_cs), .p2_time_cs(p2_time_cs), .winner(winner)
  );

  race_controller #(.CLK_FREQ(1000), .COUNTDOWN_SEC(3), .TIME_MAX(16'd20)) u_sat (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
    .abort_pulse(abort_pulse), .p1_finish(p1_finish), .p2_finish(p2_finish),
    .state(s_state), .countdown(s_countdown), .go_pulse(s_go_pulse), .race_cs(s_race_cs),
    .p1_time_cs(s_p1_time_cs), .p2_time_cs(s_p2_time_cs), .winner(s_winner)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1; step(1); start_pulse = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_pulse = 1'b1; step(1); pause_pulse = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_pulse = 1'b1; step(1); abort_pulse = 1'b0;
  endtask

  // Leaves the bench on the cycle where RACING and go_pulse first appear.
  task automatic start_race();
    pulse_start(); pulse_start(); step(3000);
  endtask

  task automatic test_reset_countdown();
    rst_n = 1'b0; step(3);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (countdown !== 4'd0) begin failures++; $display("FAIL rst_countdown got=%0d exp=0", countdown); end
    checks++; if (go_pulse !== 1'b0) begin failures++; $display("FAIL rst_go got=%0b exp=0", go_pulse); end
    checks++; if ({race_cs, p1_time_cs, p2_time_cs} !== 48'd0) begin failures++; $display("FAIL rst_times got=%0d/%0d/%0d exp=0", race_cs, p1_time_cs, p2_time_cs); end
    checks++; if (winner !== 2'd0) begin failures++; $display("FAIL rst_winner got=%0d exp=0", winner); end
    rst_n = 1'b1; step(2);
    pulse_start();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL cd_setting got=%0d exp=1", state); end
    pulse_start();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL cd_state got=%0d exp=3", state); end
    checks++; if (countdown !== 4'd3) begin failures++; $display("FAIL cd_load got=%0d exp=3", countdown); end
    step(999);
    checks++; if (countdown !== 4'd3) begin failures++; $display("FAIL cd_999 got=%0d exp=3", countdown); end
    step(1);
    checks++; if (countdown !== 4'd2) begin failures++; $display("FAIL cd_1000 got=%0d exp=2", countdown); end
    step(1999);
    checks++; if (state !== 3'd3 || go_pulse !== 1'b0) begin failures++; $display("FAIL cd_2999 state=%0d go=%0b exp=3/0", state, go_pulse); end
    checks++; if (countdown !== 4'd1) begin failures++; $display("FAIL cd_last got=%0d exp=1", countdown); end
    step(1);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL go_state got=%0d exp=4", state); end
    checks++; if (go_pulse !== 1'b1) begin failures++; $display("FAIL go_high got=%0b exp=1", go_pulse); end
    checks++; if (countdown !== 4'd0) begin failures++; $display("FAIL go_countdown got=%0d exp=0", countdown); end
    step(1);
    checks++; if (go_pulse !== 1'b0) begin failures++; $display("FAIL go_once got=%0b exp=0", go_pulse); end
  endtask

  task automatic test_finish_order();
    step(499);
    checks++; if (race_cs !== 16'd50) begin failures++; $display("FAIL fin_race got=%0d exp=50", race_cs); end
    p2_finish = 1'b1; step(1);
    checks++; if (state !== 3'd6) begin failures++; $display("FAIL fin_state got=%0d exp=6", state); end
    checks++; if (winner !== 2'd2) begin failures++; $display("FAIL fin_winner got=%0d exp=2", winner); end
    checks++; if (p2_time_cs !== 16'd50) begin failures++; $display("FAIL fin_p2 got=%0d exp=50", p2_time_cs); end
    checks++; if (p1_time_cs !== 16'd0) begin failures++; $display("FAIL fin_p1_unset got=%0d exp=0", p1_time_cs); end
    step(199);
    p1_finish = 1'b1; step(1);
    checks++; if (p1_time_cs !== 16'd50) begin failures++; $display("FAIL fin_p1_late got=%0d exp=50", p1_time_cs); end
    checks++; if (winner !== 2'd2) begin failures++; $display("FAIL fin_winner_kept got=%0d exp=2", winner); end
    checks++; if (race_cs !== 16'd50) begin failures++; $display("FAIL fin_frozen got=%0d exp=50", race_cs); end
    pulse_start();
    checks++; if (state !== 3'd0 || winner !== 2'd0) begin failures++; $display("FAIL fin_idle state=%0d winner=%0d exp=0/0", state, winner); end
    checks++; if ({race_cs, p1_time_cs, p2_time_cs} !== 48'd0) begin failures++; $display("FAIL fin_idle_clear got=%0d/%0d/%0d exp=0", race_cs, p1_time_cs, p2_time_cs); end
    p1_finish = 1'b0; p2_finish = 1'b0; step(1);
  endtask

  task automatic test_pause();
    start_race();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL pz_racing got=%0d exp=4", state); end
    step(100);
    checks++; if (race_cs !== 16'd10) begin failures++; $display("FAIL pz_before got=%0d exp=10", race_cs); end
    pulse_pause();
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL pz_state got=%0d exp=5", state); end
    for (int i = 0; i < 400; i++) begin
      step(1);
      checks++; if (race_cs !== 16'd10 || state !== 3'd5) begin failures++; $display("FAIL pz_hold cyc=%0d race=%0d state=%0d exp=10/5", i, race_cs, state); end
    end
    pulse_pause();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL pz_resume got=%0d exp=4", state); end
    step(100);
    checks++; if (race_cs !== 16'd20) begin failures++; $display("FAIL pz_after got=%0d exp=20", race_cs); end
    pulse_abort();
  endtask

  task automatic test_tie_and_zero();
    start_race(); step(50);
    checks++; if (race_cs !== 16'd5) begin failures++; $display("FAIL tie_race got=%0d exp=5", race_cs); end
    p1_finish = 1'b1; p2_finish = 1'b1; pause_pulse = 1'b1; step(1); pause_pulse = 1'b0;
    checks++; if (state !== 3'd6) begin failures++; $display("FAIL tie_state got=%0d exp=6", state); end
    checks++; if (winner !== 2'd3) begin failures++; $display("FAIL tie_winner got=%0d exp=3", winner); end
    checks++; if (p1_time_cs !== 16'd5 || p2_time_cs !== 16'd5) begin failures++; $display("FAIL tie_times got=%0d/%0d exp=5/5", p1_time_cs, p2_time_cs); end
    pulse_start(); p1_finish = 1'b0; p2_finish = 1'b0; step(1);
    start_race();
    p1_finish = 1'b1; step(1);
    checks++; if (p1_time_cs !== 16'd1) begin failures++; $display("FAIL zero_stamp got=%0d exp=1", p1_time_cs); end
    checks++; if (winner !== 2'd1) begin failures++; $display("FAIL zero_winner got=%0d exp=1", winner); end
    pulse_start(); p1_finish = 1'b0; step(1);
  endtask

  task automatic test_abort_reset();
    pulse_start(); pulse_start(); step(1500);
    pulse_abort();
    checks++; if (state !== 3'd0 || countdown !== 4'd0) begin failures++; $display("FAIL ab_cd state=%0d cd=%0d exp=0/0", state, countdown); end
    start_race(); step(200);
    checks++; if (race_cs !== 16'd20) begin failures++; $display("FAIL ab_pre got=%0d exp=20", race_cs); end
    pulse_abort();
    checks++; if (state !== 3'd0 || race_cs !== 16'd0 || go_pulse !== 1'b0) begin failures++; $display("FAIL ab_race state=%0d race=%0d go=%0b exp=0", state, race_cs, go_pulse); end
    checks++; if ({p1_time_cs, p2_time_cs, winner} !== 34'd0) begin failures++; $display("FAIL ab_clear got=%0d/%0d/%0d exp=0", p1_time_cs, p2_time_cs, winner); end
    start_race(); step(100);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++; if (state !== 3'd0 || race_cs !== 16'd0) begin failures++; $display("FAIL async_rst state=%0d race=%0d exp=0/0", state, race_cs); end
    #1; rst_n = 1'b1; step(2);
  endtask

  task automatic test_saturate_ignored();
    start_race(); step(300);
    checks++; if (race_cs !== 16'd30) begin failures++; $display("FAIL sat_ref got=%0d exp=30", race_cs); end
    checks++; if (s_race_cs !== 16'd20) begin failures++; $display("FAIL sat_cap got=%0d exp=20", s_race_cs); end
    step(100);
    checks++; if (s_race_cs !== 16'd20) begin failures++; $display("FAIL sat_nowrap got=%0d exp=20", s_race_cs); end
    pulse_start();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL ign_start got=%0d exp=4", state); end
    pulse_abort();
    pulse_start(); pulse_pause();
    checks++; if (state !== 3'd1 || countdown !== 4'd0) begin failures++; $display("FAIL ign_pause state=%0d cd=%0d exp=1/0", state, countdown); end
    pulse_abort();
  endtask

  initial begin
    test_reset_countdown();
    test_finish_order();
    test_pause();
    test_tie_and_zero();
    test_abort_reset();
    test_saturate_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
